branch_resolve_unit: RTL and testbench

Execute-stage counterpart of the BHT/BTB branch predictor. It carries each fetched instruction's prediction (taken flag, predicted target) through the Decode and Execute pipeline registers and compares it with the branch outcome resolved in Execute. It produces the predictor update strobes, the mispredict flush, and the corrected fetch address. It also keeps saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_resolve_unit_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 91 +++++++++
 tb/tb_branch_resolve_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the fetch/hazard/execute pipeline and branch_resolve_unit.
// The master drives fetch predictions, hazard controls and E-stage results; the slave resolves them.
interface branch_resolve_unit_if #(
  parameter int unsigned ENTRY_BITS = 4,
  parameter int unsigned CNT_BITS   = 16
);
  logic [31:0]           PC_F;
  logic                  PrPCSrc_F;
  logic [31:0]           PrALUResult_F;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  Branch_E;
  logic                  CondEx_E;
  logic [31:0]           ALUResult_E;
  logic [ENTRY_BITS-1:0] PC_E_idx;
  logic                  WE_PrPCSrc;
  logic                  WE_PrALUResult;
  logic                  PCSrc_E;
  logic [31:0]           ALUResult_Upd;
  logic                  Mispredict_E;
  logic [31:0]           RedirectPC_E;
  logic [CNT_BITS-1:0]   BranchCnt;
  logic [CNT_BITS-1:0]   MispredCnt;

  modport master (
    output PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, FlushE,
           Branch_E, CondEx_E, ALUResult_E,
    input  PC_E_idx, WE_PrPCSrc, WE_PrALUResult, PCSrc_E, ALUResult_Upd,
           Mispredict_E, RedirectPC_E, BranchCnt, MispredCnt
  );

  modport slave (
    input  PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, FlushE,
           Branch_E, CondEx_E, ALUResult_E,
    output PC_E_idx, WE_PrPCSrc, WE_PrALUResult, PCSrc_E, ALUResult_Upd,
           Mispredict_E, RedirectPC_E, BranchCnt, MispredCnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries BHT/BTB predictions through D and E, checks them against the resolved branch,
// and produces predictor updates, the mispredict flush/redirect and performance counters.
module branch_resolve_unit #(
  parameter int unsigned ENTRY_BITS = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input logic                clk,
  input logic                RESET_N,
  branch_resolve_unit_if.slave bus
);

  logic                valid_d, pred_tk_d;
  logic [31:0]         pred_tgt_d, pc_d;
  logic                valid_e, pred_tk_e;
  logic [31:0]         pred_tgt_e, pc_e;
  logic [CNT_BITS-1:0] branch_cnt, mispred_cnt;

  logic act, tgt_ne, dir_miss, tgt_miss, mispredict;

  always_comb begin
    act        = valid_e & bus.Branch_E & bus.CondEx_E;
    tgt_ne     = (pred_tgt_e != bus.ALUResult_E);
    // a valid non-branch predicted taken lands here too (aliased BHT entry)
    dir_miss   = valid_e & (pred_tk_e != act);
    tgt_miss   = act & pred_tk_e & tgt_ne;
    mispredict = dir_miss | tgt_miss;
  end

  // Mispredict or hazard flush clears D, and wins over a stall hold.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_d    <= 1'b0;
      pred_tk_d  <= 1'b0;
      pred_tgt_d <= '0;
      pc_d       <= '0;
    end else if (bus.FlushD | mispredict) begin
      valid_d    <= 1'b0;
      pred_tk_d  <= 1'b0;
      pred_tgt_d <= '0;
      pc_d       <= '0;
    end else if (!bus.StallD) begin
      valid_d    <= 1'b1;
      pred_tk_d  <= bus.PrPCSrc_F;
      pred_tgt_d <= bus.PrALUResult_F;
      pc_d       <= bus.PC_F;
    end
  end

  // A stalled D slot feeds E a cleared bubble rather than a duplicate.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_e    <= 1'b0;
      pred_tk_e  <= 1'b0;
      pred_tgt_e <= '0;
      pc_e       <= '0;
    end else if (bus.FlushE | mispredict | bus.StallD) begin
      valid_e    <= 1'b0;
      pred_tk_e  <= 1'b0;
      pred_tgt_e <= '0;
      pc_e       <= '0;
    end else begin
      valid_e    <= valid_d;
      pred_tk_e  <= pred_tk_d;
      pred_tgt_e <= pred_tgt_d;
      pc_e       <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (valid_e && bus.Branch_E && branch_cnt != '1)
        branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign bus.PC_E_idx       = pc_e[ENTRY_BITS+1:2];
  assign bus.WE_PrPCSrc     = dir_miss;
  assign bus.WE_PrALUResult = act & (~pred_tk_e | tgt_ne);
  assign bus.PCSrc_E        = act;
  assign bus.ALUResult_Upd  = bus.ALUResult_E;
  assign bus.Mispredict_E   = mispredict;
  assign bus.RedirectPC_E   = act ? bus.ALUResult_E : pc_e + 32'd4;
  assign bus.BranchCnt      = branch_cnt;
  assign bus.MispredCnt     = mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: each fetched prediction carries its expected
// resolution through a D/E slot queue and is checked when it reaches Execute.
module tb_branch_resolve_unit;
  localparam int unsigned EB = 4;
  // narrow counters keep saturation reachable in a short run
  localparam int unsigned CB = 8;
  localparam logic [31:0] CMAX = (32'd1 << CB) - 32'd1;

  logic clk = 1'b0;
  logic RESET_N;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ENTRY_BITS(EB), .CNT_BITS(CB)) bus ();
  branch_resolve_unit #(.ENTRY_BITS(EB), .CNT_BITS(CB)) dut (
    .clk(clk), .RESET_N(RESET_N), .bus(bus.slave)
  );

  typedef struct {
    logic        v, tk, br, cond;
    logic [31:0] tgt, pc, alu;
    logic        mp, we1, we2, pcsrc;
    logic [31:0] redir;
  } rec_t;

  rec_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] bcnt, mcnt, fpc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic br, input logic cond, input logic [31:0] alu);
    rec_t r;
    logic act;
    r.v = 1'b1; r.pc = pc; r.tk = tk; r.tgt = tgt; r.br = br; r.cond = cond; r.alu = alu;
    act     = br & cond;
    r.pcsrc = act;
    r.we1   = (tk != act);
    r.we2   = act & (!tk | (tgt != alu));
    r.mp    = r.we1 | (act & tk & (tgt != alu));
    r.redir = act ? alu : pc + 32'd4;
    return r;
  endfunction

  function automatic rec_t bubble();
    rec_t r;
    r.v = 1'b0; r.tk = 1'b0; r.br = 1'b0; r.cond = 1'b0;
    r.tgt = '0; r.pc = '0; r.alu = '0;
    r.mp = 1'b0; r.we1 = 1'b0; r.we2 = 1'b0; r.pcsrc = 1'b0; r.redir = '0;
    return r;
  endfunction

  function automatic rec_t nb();
    fpc = fpc + 32'd4;
    return mk(fpc, 1'b0, 32'h0, 1'b0, 1'(($urandom)), $urandom);
  endfunction

  // One cycle: called at negedge with f being the new fetch; checks the E slot, then clocks.
  task automatic step(input rec_t f, input logic stall, input logic fd, input logic fe);
    rec_t e, d, ne, nd;
    logic [31:0] alu;
    logic kill;
    e = sb.pop_front();
    d = sb.pop_front();
    bus.PC_F = f.pc; bus.PrPCSrc_F = f.tk; bus.PrALUResult_F = f.tgt;
    bus.StallD = stall; bus.FlushD = fd; bus.FlushE = fe;
    if (e.v) begin
      bus.Branch_E = e.br; bus.CondEx_E = e.cond; alu = e.alu;
    end else begin
      bus.Branch_E = 1'($urandom); bus.CondEx_E = 1'($urandom); alu = $urandom;
    end
    bus.ALUResult_E = alu;
    #1;
    check_val("mispredict", 32'(bus.Mispredict_E), 32'(e.mp));
    check_val("we_pcsrc", 32'(bus.WE_PrPCSrc), 32'(e.we1));
    check_val("we_target", 32'(bus.WE_PrALUResult), 32'(e.we2));
    check_val("pcsrc", 32'(bus.PCSrc_E), 32'(e.pcsrc));
    check_val("alu_upd", bus.ALUResult_Upd, alu);
    check_val("branch_cnt", 32'(bus.BranchCnt), bcnt);
    check_val("mispred_cnt", 32'(bus.MispredCnt), mcnt);
    if (e.v) begin
      check_val("redirect", bus.RedirectPC_E, e.redir);
      check_val("pc_idx", 32'(bus.PC_E_idx), 32'(e.pc[EB+1:2]));
    end
    if (e.v && e.br && bcnt != CMAX) bcnt = bcnt + 1;
    if (e.v && e.mp && mcnt != CMAX) mcnt = mcnt + 1;
    kill = e.v & e.mp;
    ne = (fe | kill | stall) ? bubble() : d;
    nd = (fd | kill) ? bubble() : (stall ? d : f);
    sb.push_back(ne);
    sb.push_back(nd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(nb(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_model();
    sb.delete();
    sb.push_back(bubble());
    sb.push_back(bubble());
    bcnt = '0;
    mcnt = '0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_mispredict", 32'(bus.Mispredict_E), 32'h0);
    check_val("rst_we_pcsrc", 32'(bus.WE_PrPCSrc), 32'h0);
    check_val("rst_we_target", 32'(bus.WE_PrALUResult), 32'h0);
    check_val("rst_pcsrc", 32'(bus.PCSrc_E), 32'h0);
    check_val("rst_idx", 32'(bus.PC_E_idx), 32'h0);
    check_val("rst_redirect", bus.RedirectPC_E, 32'h4);
    check_val("rst_alu_upd", bus.ALUResult_Upd, 32'h1234_5678);
    check_val("rst_branch_cnt", 32'(bus.BranchCnt), 32'h0);
    check_val("rst_mispred_cnt", 32'(bus.MispredCnt), 32'h0);
  endtask

  initial begin
    logic tk, br, cond, coin;
    logic [31:0] alu, tgt;
    fpc = 32'h1000;
    RESET_N = 1'b0;
    bus.PC_F = '0; bus.PrPCSrc_F = 1'b0; bus.PrALUResult_F = '0;
    bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    bus.Branch_E = 1'b1; bus.CondEx_E = 1'b1; bus.ALUResult_E = 32'h1234_5678;
    reset_model();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    RESET_N = 1'b1;

    // correct prediction, then direction/target misses and the aliased cases
    step(mk(32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200), 1'b0, 1'b0, 1'b0); fill(3);
    step(mk(32'h94, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40), 1'b0, 1'b0, 1'b0); fill(4);
    step(mk(32'h3C, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80), 1'b0, 1'b0, 1'b0); fill(4);
    step(mk(32'h50, 1'b1, 32'h70, 1'b0, 1'b1, 32'h70), 1'b0, 1'b0, 1'b0); fill(4);
    step(mk(32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h10), 1'b0, 1'b0, 1'b0); fill(4);
    step(mk(32'h60, 1'b1, 32'h200, 1'b1, 1'b1, 32'h300), 1'b0, 1'b0, 1'b0); fill(4);

    // three-cycle stall, then a stall coinciding with a mispredict in E
    fill(1);
    for (int unsigned i = 0; i < 3; i++) step(nb(), 1'b1, 1'b0, 1'b0);
    fill(3);
    step(mk(32'h2C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400), 1'b0, 1'b0, 1'b0);
    step(nb(), 1'b0, 1'b0, 1'b0);
    step(nb(), 1'b1, 1'b0, 1'b0);
    fill(3);
    step(mk(32'h48, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0), 1'b0, 1'b0, 1'b0);
    step(nb(), 1'b0, 1'b0, 1'b0);
    step(nb(), 1'b0, 1'b1, 1'b1);
    fill(3);

    for (int unsigned i = 0; i < 300; i++) begin
      fpc  = fpc + 32'd4;
      tk   = 1'($urandom);
      br   = 1'($urandom);
      cond = 1'($urandom);
      coin = ($urandom_range(0, 3) != 0);
      alu  = $urandom;
      tgt  = tk ? (coin ? alu : $urandom) : 32'h0;
      step(mk(fpc, tk, tgt, br, cond, alu),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 19) == 0));
    end

    // asynchronous reset mid-stream: state clears without a clock edge
    RESET_N = 1'b0;
    bus.Branch_E = 1'b1; bus.CondEx_E = 1'b1; bus.ALUResult_E = 32'h1234_5678;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    reset_model();
    fill(3);

    // continuous mispredicts drive both counters into saturation
    for (int unsigned i = 0; i < 900; i++) begin
      fpc = fpc + 32'd4;
      step(mk(fpc, 1'b0, 32'h0, 1'b1, 1'b1, fpc + 32'h100), 1'b0, 1'b0, 1'b0);
    end
    check_val("mispred_sat", 32'(bus.MispredCnt), CMAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
